// File: rtl/pcie_tx_req_arb.sv
// Round-robin arbiter for the PRP MRd, DMA MRd and DMA MWr TLP request
// channels; holds the winner to the TLP generator and bounds outstanding MRds.
//
// Ports:
//   pcie_user_clk / pcie_user_rst  clock, synchronous active-high reset
//   tx_prp_mrd_* / tx_dma_mrd_* / tx_dma_mwr_*
//                                  request channels: req, tag, len, addr in;
//                                  one-cycle req_ack out
//   tx_dma_mwr_data_last           last MWr payload beat, to the MWr requester
//   tlp_req_*                      held request to the generator (valid/ready)
//   tlp_mwr_data_last              last MWr payload beat, from the generator
//   cpld_tag_done                  one MRd fully completed
//   mrd_outstanding                current outstanding-MRd count
module pcie_tx_req_arb #(
  parameter int C_PCIE_ADDR_WIDTH     = 48,
  parameter int P_MAX_OUTSTANDING_MRD = 32
) (
  input  logic                         pcie_user_clk,
  input  logic                         pcie_user_rst,
  input  logic                         tx_prp_mrd_req,
  input  logic [7:0]                   tx_prp_mrd_tag,
  input  logic [10:0]                  tx_prp_mrd_len,
  input  logic [C_PCIE_ADDR_WIDTH-3:0] tx_prp_mrd_addr,
  output logic                         tx_prp_mrd_req_ack,
  input  logic                         tx_dma_mrd_req,
  input  logic [7:0]                   tx_dma_mrd_tag,
  input  logic [10:0]                  tx_dma_mrd_len,
  input  logic [C_PCIE_ADDR_WIDTH-3:0] tx_dma_mrd_addr,
  output logic                         tx_dma_mrd_req_ack,
  input  logic                         tx_dma_mwr_req,
  input  logic [7:0]                   tx_dma_mwr_tag,
  input  logic [10:0]                  tx_dma_mwr_len,
  input  logic [C_PCIE_ADDR_WIDTH-3:0] tx_dma_mwr_addr,
  output logic                         tx_dma_mwr_req_ack,
  output logic                         tx_dma_mwr_data_last,
  output logic                         tlp_req_valid,
  input  logic                         tlp_req_ready,
  output logic [1:0]                   tlp_req_type,
  output logic [7:0]                   tlp_req_tag,
  output logic [10:0]                  tlp_req_len,
  output logic [C_PCIE_ADDR_WIDTH-3:0] tlp_req_addr,
  input  logic                         tlp_mwr_data_last,
  input  logic                         cpld_tag_done,
  output logic [5:0]                   mrd_outstanding
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_MWR_DATA
  } state_t;

  localparam logic [1:0] T_PRP = 2'd0;
  localparam logic [1:0] T_DMA = 2'd1;
  localparam logic [1:0] T_MWR = 2'd2;

  localparam logic [5:0] MAX_MRD = 6'(P_MAX_OUTSTANDING_MRD);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] rr_ptr;
  logic [5:0] mrd_cnt;
  logic       mrd_ok;
  logic [2:0] elig;
  logic [2:0] gnt;
  logic       accept;
  logic       mrd_inc;
  logic       mrd_dec;

  assign mrd_ok = mrd_cnt < MAX_MRD;

  assign elig = {tx_dma_mwr_req,
                 tx_dma_mrd_req & mrd_ok,
                 tx_prp_mrd_req & mrd_ok};

  // Priority starts at the channel after the last winner.
  always_comb begin
    gnt = 3'b000;
    if (state == S_IDLE) begin
      case (rr_ptr)
        2'd1: begin
          if (elig[1])      gnt = 3'b010;
          else if (elig[2]) gnt = 3'b100;
          else if (elig[0]) gnt = 3'b001;
        end
        2'd2: begin
          if (elig[2])      gnt = 3'b100;
          else if (elig[0]) gnt = 3'b001;
          else if (elig[1]) gnt = 3'b010;
        end
        default: begin
          if (elig[0])      gnt = 3'b001;
          else if (elig[1]) gnt = 3'b010;
          else if (elig[2]) gnt = 3'b100;
        end
      endcase
    end
  end

  always_ff @(posedge pcie_user_clk) begin
    if (pcie_user_rst) state <= S_IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (|gnt) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (accept) begin
          // A last beat already present at acceptance skips MWR_DATA.
          if (tlp_req_type == T_MWR && !tlp_mwr_data_last)
            state_nxt = S_MWR_DATA;
          else
            state_nxt = S_IDLE;
        end
      end
      S_MWR_DATA: begin
        if (tlp_mwr_data_last) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tlp_req_valid        = state == S_ISSUE;
    accept               = tlp_req_valid & tlp_req_ready;
    tx_dma_mwr_data_last = tlp_mwr_data_last &
                           ((state == S_MWR_DATA) |
                            (accept & (tlp_req_type == T_MWR)));
  end

  always_ff @(posedge pcie_user_clk) begin
    if (pcie_user_rst) begin
      tx_prp_mrd_req_ack <= 1'b0;
      tx_dma_mrd_req_ack <= 1'b0;
      tx_dma_mwr_req_ack <= 1'b0;
      tlp_req_type       <= '0;
      tlp_req_tag        <= '0;
      tlp_req_len        <= '0;
      tlp_req_addr       <= '0;
      rr_ptr             <= 2'd0;
    end else begin
      tx_prp_mrd_req_ack <= gnt[0];
      tx_dma_mrd_req_ack <= gnt[1];
      tx_dma_mwr_req_ack <= gnt[2];
      if (|gnt) begin
        unique case (1'b1)
          gnt[0]: begin
            tlp_req_type <= T_PRP;
            tlp_req_tag  <= tx_prp_mrd_tag;
            tlp_req_len  <= tx_prp_mrd_len;
            tlp_req_addr <= tx_prp_mrd_addr;
            rr_ptr       <= 2'd1;
          end
          gnt[1]: begin
            tlp_req_type <= T_DMA;
            tlp_req_tag  <= tx_dma_mrd_tag;
            tlp_req_len  <= tx_dma_mrd_len;
            tlp_req_addr <= tx_dma_mrd_addr;
            rr_ptr       <= 2'd2;
          end
          default: begin
            tlp_req_type <= T_MWR;
            tlp_req_tag  <= tx_dma_mwr_tag;
            tlp_req_len  <= tx_dma_mwr_len;
            tlp_req_addr <= tx_dma_mwr_addr;
            rr_ptr       <= 2'd0;
          end
        endcase
      end
    end
  end

  // Completion at zero count is dropped; issue plus completion cancels out.
  assign mrd_inc = accept & (tlp_req_type != T_MWR);
  assign mrd_dec = cpld_tag_done & (mrd_cnt != 6'd0);

  always_ff @(posedge pcie_user_clk) begin
    if (pcie_user_rst)          mrd_cnt <= 6'd0;
    else if (mrd_inc & !mrd_dec) mrd_cnt <= mrd_cnt + 6'd1;
    else if (!mrd_inc & mrd_dec) mrd_cnt <= mrd_cnt - 6'd1;
  end

  assign mrd_outstanding = mrd_cnt;

endmodule

// File: tb/tb_pcie_tx_req_arb.sv
// Scoreboard bench for pcie_tx_req_arb: directed request sequences, grants
// checked in order by a monitor against hand-computed expected TLP requests.
module tb_pcie_tx_req_arb;

  localparam int AW   = 48;
  localparam int FW   = AW - 2;
  localparam int PMAX = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          prp_req, dma_req, mwr_req;
  logic [7:0]    prp_tag, dma_tag, mwr_tag;
  logic [10:0]   prp_len, dma_len, mwr_len;
  logic [FW-1:0] prp_addr, dma_addr, mwr_addr;
  logic          prp_ack, dma_ack, mwr_ack;
  logic          dl_out;
  logic          valid, ready;
  logic [1:0]    typ;
  logic [7:0]    tag;
  logic [10:0]   len;
  logic [FW-1:0] addr;
  logic          dl_in, cpld;
  logic [5:0]    cnt;

  always #5 clk = ~clk;

  pcie_tx_req_arb #(
    .C_PCIE_ADDR_WIDTH(AW),
    .P_MAX_OUTSTANDING_MRD(PMAX)
  ) dut (
    .pcie_user_clk(clk),
    .pcie_user_rst(rst),
    .tx_prp_mrd_req(prp_req),
    .tx_prp_mrd_tag(prp_tag),
    .tx_prp_mrd_len(prp_len),
    .tx_prp_mrd_addr(prp_addr),
    .tx_prp_mrd_req_ack(prp_ack),
    .tx_dma_mrd_req(dma_req),
    .tx_dma_mrd_tag(dma_tag),
    .tx_dma_mrd_len(dma_len),
    .tx_dma_mrd_addr(dma_addr),
    .tx_dma_mrd_req_ack(dma_ack),
    .tx_dma_mwr_req(mwr_req),
    .tx_dma_mwr_tag(mwr_tag),
    .tx_dma_mwr_len(mwr_len),
    .tx_dma_mwr_addr(mwr_addr),
    .tx_dma_mwr_req_ack(mwr_ack),
    .tx_dma_mwr_data_last(dl_out),
    .tlp_req_valid(valid),
    .tlp_req_ready(ready),
    .tlp_req_type(typ),
    .tlp_req_tag(tag),
    .tlp_req_len(len),
    .tlp_req_addr(addr),
    .tlp_mwr_data_last(dl_in),
    .cpld_tag_done(cpld),
    .mrd_outstanding(cnt)
  );

  typedef struct packed {
    logic [1:0]    typ;
    logic [7:0]    tag;
    logic [10:0]   len;
    logic [FW-1:0] addr;
  } exp_t;

  exp_t exp_q[$];

  int checks    = 0;
  int failures  = 0;
  int ack_total = 0;
  int dl_cnt    = 0;
  bit rearm     = 1'b0;
  bit auto_cpl  = 1'b0;
  bit acc       = 1'b0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] onehot(logic [1:0] t);
    logic [2:0] one;
    one = 3'b001;
    return one << t;
  endfunction

  function automatic logic anyack();
    return prp_ack | dma_ack | mwr_ack;
  endfunction

  task automatic push(logic [1:0] t);
    case (t)
      2'd0:    exp_q.push_back({t, prp_tag, prp_len, prp_addr});
      2'd1:    exp_q.push_back({t, dma_tag, dma_len, dma_addr});
      default: exp_q.push_back({t, mwr_tag, mwr_len, mwr_addr});
    endcase
  endtask

  // Monitor: every ack pops the next expected grant.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (dl_out) dl_cnt++;
      if ({mwr_ack, dma_ack, prp_ack} != 3'b000) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", {mwr_ack, dma_ack, prp_ack}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("grant",
              {mwr_ack, dma_ack, prp_ack, valid, typ, tag, len, addr},
              {onehot(e.typ), 1'b1, e.typ, e.tag, e.len, e.addr});
        end
      end
    end
  end

  // One cycle; requesters drop req on ack, completer answers MRds.
  task automatic tick();
    @(negedge clk);
    acc = valid & ready & (typ != 2'd2);
    @(posedge clk);
    #1;
    ack_total += int'(prp_ack) + int'(dma_ack) + int'(mwr_ack);
    if (!rearm) begin
      if (prp_ack) prp_req = 1'b0;
      if (dma_ack) dma_req = 1'b0;
      if (mwr_ack) mwr_req = 1'b0;
    end
    cpld = auto_cpl & acc;
  endtask

  task automatic wait_acks(int n, string name);
    int s;
    int b;
    s = ack_total;
    b = 0;
    while (ack_total < s + n && b < 60) begin
      tick();
      b++;
    end
    chk(name, ack_total - s, n);
  endtask

  initial begin
    bit seen;
    bit ok;
    int dl0;
    rst   = 1'b1;
    prp_req = 1'b0; dma_req = 1'b0; mwr_req = 1'b0;
    prp_tag = '0; prp_len = '0; prp_addr = '0;
    dma_tag = '0; dma_len = '0; dma_addr = '0;
    mwr_tag = '0; mwr_len = '0; mwr_addr = '0;
    ready = 1'b1;
    dl_in = 1'b0;
    cpld  = 1'b0;
    repeat (3) tick();

    chk("rst_valid", valid, 0);
    chk("rst_acks", {mwr_ack, dma_ack, prp_ack}, 0);
    chk("rst_fields", {typ, tag, len, addr}, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_dl", dl_out, 0);
    rst = 1'b0;
    tick();

    // Single PRP MRd
    prp_tag = 8'h05; prp_len = 11'd16; prp_addr = 46'h400;
    prp_req = 1'b1;
    push(2'd0);
    tick();
    chk("t1_ack_cycle", {prp_ack, valid, typ}, {1'b1, 1'b1, 2'd0});
    chk("t1_cnt_at_ack", cnt, 0);
    tick();
    chk("t1_ack_pulse", prp_ack, 0);
    chk("t1_valid_drop", valid, 0);
    chk("t1_cnt", cnt, 1);
    cpld = 1'b1;
    tick();
    chk("t1_cnt_done", cnt, 0);

    // Rotation with all three held; reset first so PRP leads
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dma_tag = 8'h11; dma_len = 11'h080; dma_addr = 46'h2_0000_0000;
    mwr_tag = 8'h22; mwr_len = 11'h040; mwr_addr = 46'h3FFF_FFFF_FFFF;
    prp_req = 1'b1; dma_req = 1'b1; mwr_req = 1'b1;
    auto_cpl = 1'b1;
    rearm = 1'b1;
    dl_in = 1'b1;
    dl0 = dl_cnt;
    for (int r = 0; r < 2; r++) begin
      push(2'd0); push(2'd1); push(2'd2);
    end
    wait_acks(6, "t2_acks");
    prp_req = 1'b0; dma_req = 1'b0; mwr_req = 1'b0;
    rearm = 1'b0;
    repeat (3) tick();
    chk("t2_dl_pulses", dl_cnt - dl0, 2);
    chk("t2_queue_empty", exp_q.size(), 0);
    dl_in = 1'b0;

    // MWr payload serialises the next grant
    mwr_tag = 8'h23; mwr_len = 11'h008; mwr_addr = 46'h1234;
    mwr_req = 1'b1;
    push(2'd2);
    wait_acks(1, "t3_mwr_grant");
    dma_tag = 8'h24; dma_len = 11'h7FF; dma_addr = 46'h5678;
    dma_req = 1'b1;
    push(2'd1);
    dl0 = dl_cnt;
    tick();
    seen = 1'b0;
    repeat (8) begin
      tick();
      seen |= anyack();
    end
    chk("t3_no_ack_in_data", seen, 0);
    dl_in = 1'b1;
    #1;
    chk("t3_dl_fwd", dl_out, 1);
    tick();
    dl_in = 1'b0;
    wait_acks(1, "t3_dma_after");
    chk("t3_dl_once", dl_cnt - dl0, 1);
    repeat (3) tick();
    auto_cpl = 1'b0;
    chk("t3_cnt_settled", cnt, 0);

    // Outstanding limit of 2
    prp_tag = 8'h31; dma_tag = 8'h32;
    prp_req = 1'b1; dma_req = 1'b1;
    push(2'd0); push(2'd1);
    wait_acks(2, "t4_two_mrd");
    tick();
    chk("t4_cnt_max", cnt, 2);
    prp_tag = 8'h33;
    prp_req = 1'b1; mwr_req = 1'b1;
    dl_in = 1'b1;
    push(2'd2);
    wait_acks(1, "t4_mwr_while_full");
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen |= anyack();
    end
    chk("t4_mrd_blocked", seen, 0);
    chk("t4_cnt_hold", cnt, 2);
    push(2'd0);
    cpld = 1'b1;
    tick();
    chk("t4_cnt_dec", cnt, 1);
    wait_acks(1, "t4_third_mrd");
    cpld = 1'b1;
    tick();
    chk("t4_cnt_simul", cnt, 1);
    cpld = 1'b1;
    tick();
    chk("t4_cnt_dec2", cnt, 0);
    cpld = 1'b1;
    tick();
    chk("t4_no_underflow", cnt, 0);
    dl_in = 1'b0;

    // Generator stalls for 20 cycles
    auto_cpl = 1'b1;
    ready = 1'b0;
    dma_tag = 8'h51; dma_len = 11'h200; dma_addr = 46'h12345;
    dma_req = 1'b1;
    push(2'd1);
    wait_acks(1, "t5_grant");
    prp_tag = 8'h52; prp_req = 1'b1;
    mwr_tag = 8'h53; mwr_req = 1'b1;
    dl_in = 1'b1;
    ok = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      tick();
      seen |= anyack();
      ok &= (valid === 1'b1) && (typ === 2'd1) && (tag === 8'h51) &&
            (len === 11'h200) && (addr === 46'h12345);
    end
    chk("t5_hold_stable", ok, 1);
    chk("t5_no_ack", seen, 0);
    ready = 1'b1;
    push(2'd2); push(2'd0);
    wait_acks(2, "t5_after_ready");
    repeat (3) tick();
    dl_in = 1'b0;

    // Reset during MWR_DATA
    auto_cpl = 1'b0;
    prp_tag = 8'h61; prp_req = 1'b1;
    push(2'd0);
    wait_acks(1, "t6_prp");
    tick();
    chk("t6_cnt_pre", cnt, 1);
    mwr_tag = 8'h64; mwr_req = 1'b1;
    push(2'd2);
    wait_acks(1, "t6_mwr");
    tick();
    prp_tag = 8'h62; prp_req = 1'b1;
    dma_tag = 8'h63; dma_req = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      tick();
      seen |= anyack();
    end
    chk("t6_wait_no_ack", seen, 0);
    rst = 1'b1;
    tick();
    chk("t6_rst_valid", valid, 0);
    chk("t6_rst_cnt", cnt, 0);
    chk("t6_rst_fields", {typ, tag, len, addr}, 0);
    dl_in = 1'b1;
    #1;
    chk("t6_not_mwr_data", dl_out, 0);
    dl_in = 1'b0;
    rst = 1'b0;
    push(2'd0); push(2'd1);
    wait_acks(2, "t6_prp_first");
    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
